stopwatch_timer_ctrl: RTL and testbench

Mode and sequencing controller for the shared h:m:s counter chain, built from three cascaded `counter` instances (sec, min, hour).
- Turns single-cycle button pulses and the 1 Hz `sec_tick` into the chain's control inputs: `work_en`, `up_down`, `setup_imp`, `setup_data`, `timer_reset`.
- Runs the chain as a stopwatch (count up) or as a countdown timer with field-by-field setting and an alarm.
- Sits between the button debouncers / 1 Hz prescaler and the counter chain; `rezhim` feeds the display mux.

---
 rtl/stopwatch_timer_ctrl_pkg.sv | 51 +++++
 rtl/stopwatch_timer_ctrl_wrap.sv | 12 +
 rtl/stopwatch_timer_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_stopwatch_timer_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_timer_ctrl_pkg.sv
// Shared types and helpers for the stopwatch/timer controller.
// Holds the mode FSM encoding, field indices and display mode codes.
package def;

    function automatic int numofbits(input int value);
        int n;
        n = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) n = i + 1;
        end
        return n;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef enum logic [2:0] {
        SW_STOP,
        SW_RUN,
        TMR_SET,
        TMR_RUN,
        TMR_PAUSE,
        TMR_ALARM
    } state_t;

    localparam logic [1:0] FLD_SEC  = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_HOUR = 2'd2;

    localparam logic [1:0] RZ_SW    = 2'd0;
    localparam logic [1:0] RZ_SET   = 2'd1;
    localparam logic [1:0] RZ_RUN   = 2'd2;
    localparam logic [1:0] RZ_ALARM = 2'd3;

    function automatic logic [1:0] rezhim_of(input state_t s);
        logic [1:0] r;
        r = RZ_SW;
        case (s)
            TMR_SET:   r = RZ_SET;
            TMR_RUN:   r = RZ_RUN;
            TMR_PAUSE: r = RZ_RUN;
            TMR_ALARM: r = RZ_ALARM;
            default:   r = RZ_SW;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_wrap.sv
// Wrapped increment of one h:m:s field: max rolls over to zero.
module field_wrap_inc #(
    parameter int W = 6
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] next
);

    assign next = (value >= max_val) ? '0 : value + W'(1);

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// Mode/sequencing controller for the sec/min/hour counter chain.
// Drives stopwatch counting, countdown setting, run/pause and the alarm.
module stopwatch_timer_ctrl
    import def::*;
#(
    parameter int SEC_MAX   = 59,
    parameter int MIN_MAX   = 59,
    parameter int HOUR_MAX  = 23,
    parameter int ALARM_SEC = 5,
    localparam int SEC_W    = numofbits(SEC_MAX),
    localparam int MIN_W    = numofbits(MIN_MAX),
    localparam int HOUR_W   = numofbits(HOUR_MAX),
    localparam int DATA_W   = max3(SEC_W, MIN_W, HOUR_W),
    localparam int ACNT_W   = numofbits(ALARM_SEC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_start,
    input  logic              btn_sel,
    input  logic              btn_inc,
    input  logic              sec_tick,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] cur_hour,
    output logic [1:0]        rezhim,
    output logic [2:0]        setup_imp,
    output logic [DATA_W-1:0] setup_data,
    output logic              work_en,
    output logic              up_down,
    output logic              timer_reset,
    output logic [1:0]        field_sel,
    output logic              alarm
);

    state_t state, state_n;

    logic [2:0]        setup_imp_n;
    logic [DATA_W-1:0] setup_data_n;
    logic              work_en_n;
    logic              timer_reset_n;
    logic [1:0]        field_sel_n;
    logic [ACNT_W-1:0] alarm_cnt, alarm_cnt_n;
    logic [ACNT_W-1:0] alarm_cnt_inc;

    logic b_mode, b_start, b_sel, b_inc;
    logic chain_zero;

    logic [DATA_W-1:0] wrap_val, wrap_max, wrap_next;

    // Lower-priority buttons are dropped when pulses coincide.
    assign b_mode  = btn_mode;
    assign b_start = btn_start & ~btn_mode;
    assign b_sel   = btn_sel & ~btn_mode & ~btn_start;
    assign b_inc   = btn_inc & ~btn_mode & ~btn_start & ~btn_sel;

    assign chain_zero = (cur_sec == '0) && (cur_min == '0)
                     && (cur_hour == '0);

    assign alarm_cnt_inc = alarm_cnt + ACNT_W'(1);

    always_comb begin
        wrap_val = '0;
        wrap_max = '0;
        case (field_sel)
            FLD_MIN: begin
                wrap_val = DATA_W'(cur_min);
                wrap_max = DATA_W'(MIN_MAX);
            end
            FLD_HOUR: begin
                wrap_val = DATA_W'(cur_hour);
                wrap_max = DATA_W'(HOUR_MAX);
            end
            default: begin
                wrap_val = DATA_W'(cur_sec);
                wrap_max = DATA_W'(SEC_MAX);
            end
        endcase
    end

    field_wrap_inc #(
        .W       (DATA_W)
    ) u_wrap (
        .value   (wrap_val),
        .max_val (wrap_max),
        .next    (wrap_next)
    );

    always_comb begin
        state_n       = state;
        field_sel_n   = field_sel;
        alarm_cnt_n   = alarm_cnt;
        setup_imp_n   = '0;
        setup_data_n  = '0;
        work_en_n     = 1'b0;
        timer_reset_n = 1'b0;
        unique case (state)
            SW_STOP: begin
                unique case (1'b1)
                    b_mode: begin
                        state_n       = TMR_SET;
                        timer_reset_n = 1'b1;
                        field_sel_n   = FLD_SEC;
                    end
                    b_start: state_n       = SW_RUN;
                    b_sel:   timer_reset_n = 1'b1;
                    default: ;
                endcase
            end
            SW_RUN: begin
                work_en_n = sec_tick;
                if (b_start) state_n = SW_STOP;
            end
            TMR_SET: begin
                unique case (1'b1)
                    b_mode: begin
                        state_n       = SW_STOP;
                        timer_reset_n = 1'b1;
                        field_sel_n   = FLD_SEC;
                    end
                    b_start: begin
                        if (!chain_zero) state_n = TMR_RUN;
                    end
                    b_sel: begin
                        field_sel_n = (field_sel == FLD_HOUR)
                                    ? FLD_SEC : field_sel + 2'd1;
                    end
                    b_inc: begin
                        setup_imp_n  = 3'b001 << field_sel;
                        setup_data_n = wrap_next;
                    end
                    default: ;
                endcase
            end
            TMR_RUN: begin
                // Never step the chain from 00:00:00 into an underflow.
                if (sec_tick && !chain_zero) work_en_n = 1'b1;
                if (b_start) begin
                    state_n = TMR_PAUSE;
                end else if (sec_tick && chain_zero) begin
                    state_n     = TMR_ALARM;
                    alarm_cnt_n = '0;
                end
            end
            TMR_PAUSE: begin
                unique case (1'b1)
                    b_mode: begin
                        state_n       = SW_STOP;
                        timer_reset_n = 1'b1;
                        field_sel_n   = FLD_SEC;
                    end
                    b_start: begin
                        if (!chain_zero) state_n = TMR_RUN;
                    end
                    b_sel:   state_n = TMR_SET;
                    default: ;
                endcase
            end
            TMR_ALARM: begin
                if (sec_tick) alarm_cnt_n = alarm_cnt_inc;
                if (b_mode) begin
                    state_n       = SW_STOP;
                    timer_reset_n = 1'b1;
                    field_sel_n   = FLD_SEC;
                end else if (b_start || b_sel || b_inc) begin
                    state_n = TMR_SET;
                end else if (sec_tick
                    && alarm_cnt_inc == ACNT_W'(ALARM_SEC)) begin
                    state_n = TMR_SET;
                end
            end
            default: state_n = SW_STOP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SW_STOP;
            rezhim      <= RZ_SW;
            setup_imp   <= '0;
            setup_data  <= '0;
            work_en     <= 1'b0;
            up_down     <= 1'b1;
            timer_reset <= 1'b0;
            field_sel   <= FLD_SEC;
            alarm       <= 1'b0;
            alarm_cnt   <= '0;
        end else begin
            state       <= state_n;
            rezhim      <= rezhim_of(state_n);
            setup_imp   <= setup_imp_n;
            setup_data  <= setup_data_n;
            work_en     <= work_en_n;
            up_down     <= (state_n == SW_STOP) || (state_n == SW_RUN);
            timer_reset <= timer_reset_n;
            field_sel   <= field_sel_n;
            alarm       <= (state_n == TMR_ALARM);
            alarm_cnt   <= alarm_cnt_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: directed scenarios plus random
// button/tick traffic against a behavioural model.
module tb_stopwatch_timer_ctrl;

    localparam int ALARM = 5;

    logic       clock;
    logic       reset;
    logic       btn_mode, btn_start, btn_sel, btn_inc, sec_tick;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hour;
    logic [1:0] rezhim;
    logic [2:0] setup_imp;
    logic [5:0] setup_data;
    logic       work_en, up_down, timer_reset, alarm;
    logic [1:0] field_sel;

    int total = 0;
    int bad   = 0;

    stopwatch_timer_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_start   (btn_start),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .sec_tick    (sec_tick),
        .cur_sec     (cur_sec),
        .cur_min     (cur_min),
        .cur_hour    (cur_hour),
        .rezhim      (rezhim),
        .setup_imp   (setup_imp),
        .setup_data  (setup_data),
        .work_en     (work_en),
        .up_down     (up_down),
        .timer_reset (timer_reset),
        .field_sel   (field_sel),
        .alarm       (alarm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a timer flag, a running flag, setting/ringing phases.
    bit m_tmr, m_run, m_set, m_ring;
    int m_left, m_fsel;
    int e_rz, e_imp, e_data, e_we, e_ud, e_tr, e_al, e_fsel;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap(int v, int mx);
        return (v >= mx) ? 0 : v + 1;
    endfunction

    task automatic derive();
        if (!m_tmr)      e_rz = 0;
        else if (m_ring) e_rz = 3;
        else if (m_set)  e_rz = 1;
        else             e_rz = 2;
        e_ud   = m_tmr ? 0 : 1;
        e_al   = m_ring ? 1 : 0;
        e_fsel = m_fsel;
    endtask

    task automatic model_reset();
        m_tmr = 0; m_run = 0; m_set = 0; m_ring = 0;
        m_left = 0; m_fsel = 0;
        e_imp = 0; e_data = 0; e_we = 0; e_tr = 0;
        derive();
    endtask

    task automatic model_step();
        bit m, s, se, in, tk, zero;
        int cur;
        m  = btn_mode;
        s  = btn_start && !m;
        se = btn_sel && !m && !btn_start;
        in = btn_inc && !m && !btn_start && !btn_sel;
        tk = sec_tick;
        zero = (cur_sec == 0) && (cur_min == 0) && (cur_hour == 0);
        e_imp = 0; e_data = 0; e_we = 0; e_tr = 0;
        if (!m_tmr && m_run) begin
            e_we = tk;
            if (s) m_run = 0;
        end else if (!m_tmr) begin
            if (m) begin
                m_tmr = 1; m_set = 1; e_tr = 1; m_fsel = 0;
            end else if (s) m_run = 1;
            else if (se) e_tr = 1;
        end else if (m_run) begin
            if (tk && !zero) e_we = 1;
            if (s) m_run = 0;
            else if (tk && zero) begin
                m_run = 0; m_ring = 1; m_left = ALARM;
            end
        end else if (m) begin
            m_tmr = 0; m_set = 0; m_ring = 0; e_tr = 1; m_fsel = 0;
        end else if (m_ring) begin
            if (tk) m_left--;
            if (s || se || in || m_left == 0) begin
                m_ring = 0; m_set = 1;
            end
        end else if (m_set) begin
            if (s) begin
                if (!zero) begin m_set = 0; m_run = 1; end
            end else if (se) m_fsel = (m_fsel + 1) % 3;
            else if (in) begin
                e_imp = 1 << m_fsel;
                if (m_fsel == 0)      cur = wrap(int'(cur_sec), 59);
                else if (m_fsel == 1) cur = wrap(int'(cur_min), 59);
                else                  cur = wrap(int'(cur_hour), 23);
                e_data = cur;
            end
        end else begin
            if (s) begin
                if (!zero) m_run = 1;
            end else if (se) m_set = 1;
        end
        derive();
    endtask

    task automatic compare_all();
        chk("rezhim", rezhim, e_rz);
        chk("setup_imp", setup_imp, e_imp);
        chk("setup_data", setup_data, e_data);
        chk("work_en", work_en, e_we);
        chk("up_down", up_down, e_ud);
        chk("timer_reset", timer_reset, e_tr);
        chk("field_sel", field_sel, e_fsel);
        chk("alarm", alarm, e_al);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
        btn_mode = 0; btn_start = 0; btn_sel = 0;
        btn_inc = 0; sec_tick = 0;
    endtask

    task automatic set_chain(int h, int m, int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    int we_cnt;

    initial begin
        reset = 0;
        btn_mode = 0; btn_start = 0; btn_sel = 0;
        btn_inc = 0; sec_tick = 0;
        set_chain(0, 0, 0);
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1;
        #1;
        compare_all();

        // Idle ticks in stopwatch stop.
        repeat (3) begin sec_tick = 1; cycle(); cycle(); end

        // Stopwatch run: 4 ticks, 4 work_en pulses.
        btn_start = 1; cycle();
        we_cnt = 0;
        repeat (4) begin
            sec_tick = 1; cycle(); we_cnt += int'(work_en);
            cycle(); we_cnt += int'(work_en);
        end
        chk("sw_we_cnt", we_cnt, 4);
        btn_sel = 1; cycle();
        chk("run_sel_tr", timer_reset, 0);
        btn_start = 1; cycle();
        btn_sel = 1; cycle();
        chk("stop_sel_tr", timer_reset, 1);

        // Timer set: wrapping field increments.
        btn_mode = 1; cycle();
        chk("set_tr", timer_reset, 1);
        chk("set_rz", rezhim, 1);
        set_chain(0, 0, 59);
        btn_inc = 1; cycle();
        chk("inc_sec_imp", setup_imp, 3'b001);
        chk("inc_sec_data", setup_data, 0);
        btn_sel = 1; cycle();
        btn_sel = 1; cycle();
        set_chain(23, 0, 0);
        btn_inc = 1; cycle();
        chk("inc_hr_imp", setup_imp, 3'b100);
        chk("inc_hr_data", setup_data, 0);
        set_chain(0, 0, 0);
        btn_start = 1; cycle();
        chk("start_zero_rz", rezhim, 1);

        // Countdown from 00:00:02 into the alarm.
        set_chain(0, 0, 2);
        btn_start = 1; cycle();
        chk("run_rz", rezhim, 2);
        sec_tick = 1; cycle();
        chk("t1_we", work_en, 1);
        set_chain(0, 0, 1);
        sec_tick = 1; cycle();
        chk("t2_we", work_en, 1);
        set_chain(0, 0, 0);
        sec_tick = 1; cycle();
        chk("t3_we", work_en, 0);
        chk("t3_alarm", alarm, 1);
        chk("t3_rz", rezhim, 3);
        repeat (4) begin sec_tick = 1; cycle(); cycle(); end
        chk("alarm_hold", alarm, 1);
        sec_tick = 1; cycle();
        chk("alarm_end", alarm, 0);
        chk("alarm_end_rz", rezhim, 1);

        // Mode beats start in the same cycle.
        btn_mode = 1; cycle();
        chk("back_sw_rz", rezhim, 0);
        btn_mode = 1; btn_start = 1; cycle();
        chk("prio_rz", rezhim, 1);
        chk("prio_tr", timer_reset, 1);
        sec_tick = 1; cycle();
        chk("prio_we", work_en, 0);

        // Reset in the middle of a countdown.
        set_chain(0, 1, 10);
        btn_start = 1; cycle();
        sec_tick = 1; cycle();
        reset = 0;
        #2;
        model_reset();
        compare_all();
        #2;
        reset = 1;
        cycle();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            btn_mode  = ($urandom_range(0, 13) == 0);
            btn_start = ($urandom_range(0, 7) == 0);
            btn_sel   = ($urandom_range(0, 9) == 0);
            btn_inc   = ($urandom_range(0, 5) == 0);
            sec_tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) set_chain(0, 0, 0);
            else set_chain($urandom_range(0, 23),
                           $urandom_range(0, 59),
                           $urandom_range(0, 59));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
